// File: rtl/bs_gnrtr_n_rbtr_pkg.sv
// Shared constants for the bus generator/arbiter: lane FSM encoding,
// destination-ID width and the default broadcast ID.
package bs_gnrtr_n_rbtr_pkg;

   localparam int ID_W = 8;
   localparam logic [ID_W-1:0] BCAST_DEFAULT = 8'hFF;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_POP  = 2'd1;
   localparam logic [1:0] ST_PUSH = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      POP  = ST_POP,
      PUSH = ST_PUSH
   } lane_state_e;

endpackage

// File: rtl/bus_lane.sv
// One bus: round-robin arbiter picks a pending device, pops its head word,
// then pushes it to the destination device(s) on the next cycle.
module bus_lane
   import bs_gnrtr_n_rbtr_pkg::*;
#(
   parameter int              drvrs     = 4,
   parameter int              pckg_sz   = 16,
   parameter logic [ID_W-1:0] broadcast = BCAST_DEFAULT
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [drvrs-1:0]                pndng,
   input  logic [drvrs-1:0][pckg_sz-1:0]   d_pop,
   output logic [drvrs-1:0]                pop,
   output logic [drvrs-1:0]                push,
   output logic [pckg_sz-1:0]              d_push
);

   localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;
   localparam logic [PW-1:0] LAST = PW'(drvrs - 1);

   lane_state_e          state;
   logic [PW-1:0]        last;
   logic [PW-1:0]        gnt;
   logic [PW-1:0]        sel;
   logic [PW-1:0]        cand;
   logic                 found;
   logic [pckg_sz-1:0]   word;
   logic [ID_W-1:0]      id;
   logic [drvrs-1:0]     dest;

   // Walk the devices starting one past the last grant, wrapping at drvrs-1.
   always_comb begin
      sel   = last;
      found = 1'b0;
      cand  = last;
      for (int unsigned i = 0; i < drvrs; i++) begin
         cand = (cand == LAST) ? '0 : cand + 1'b1;
         if (!found && pndng[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      word = d_pop[gnt];
      id   = word[pckg_sz-1 -: ID_W];
      dest = '0;
      for (int unsigned k = 0; k < drvrs; k++) begin
         if (id == broadcast) dest[k] = (32'(gnt) != k);
         else                 dest[k] = (32'(id) == k);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         last   <= LAST;
         gnt    <= '0;
         pop    <= '0;
         push   <= '0;
         d_push <= '0;
      end else begin
         pop  <= '0;
         push <= '0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  gnt      <= sel;
                  last     <= sel;
                  pop[sel] <= 1'b1;
                  state    <= POP;
               end
            end
            POP: begin
               // The head word is still valid on this edge; the FIFO advances on it.
               d_push <= word;
               push   <= dest;
               state  <= PUSH;
            end
            PUSH:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// Top: one independent bus_lane per bus, each lane's word fanned out to
// every device on that bus.
module bs_gnrtr_n_rbtr
   import bs_gnrtr_n_rbtr_pkg::*;
#(
   parameter int              bits      = 1,
   parameter int              drvrs     = 4,
   parameter int              pckg_sz   = 16,
   parameter logic [ID_W-1:0] broadcast = BCAST_DEFAULT
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [bits-1:0][drvrs-1:0]               pndng,
   input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
   output logic [bits-1:0][drvrs-1:0]               pop,
   output logic [bits-1:0][drvrs-1:0]               push,
   output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push
);

   logic [bits-1:0][pckg_sz-1:0] lane_word;

   for (genvar b = 0; b < bits; b++) begin : g_lane
      bus_lane #(
         .drvrs     (drvrs),
         .pckg_sz   (pckg_sz),
         .broadcast (broadcast)
      ) u_lane (
         .clk    (clk),
         .reset  (reset),
         .pndng  (pndng[b]),
         .d_pop  (D_pop[b]),
         .pop    (pop[b]),
         .push   (push[b]),
         .d_push (lane_word[b])
      );
      for (genvar k = 0; k < drvrs; k++) begin : g_fan
         assign D_push[b][k] = lane_word[b];
      end
   end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Bench for bs_gnrtr_n_rbtr (bits=1, drvrs=4, pckg_sz=16): device FIFOs as
// queues plus a transaction-schedule reference model, checked every cycle.
module tb_bs_gnrtr_n_rbtr;

   localparam int N = 4;
   localparam int W = 16;

   logic clk = 1'b0;
   logic reset;
   logic [0:0][N-1:0]        pndng;
   logic [0:0][N-1:0][W-1:0] D_pop;
   logic [0:0][N-1:0]        pop;
   logic [0:0][N-1:0]        push;
   logic [0:0][N-1:0][W-1:0] D_push;

   always #5 clk = ~clk;

   bs_gnrtr_n_rbtr #(
      .bits      (1),
      .drvrs     (N),
      .pckg_sz   (W),
      .broadcast (8'hFF)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .pndng  (pndng),
      .D_pop  (D_pop),
      .pop    (pop),
      .push   (push),
      .D_push (D_push)
   );

   logic [W-1:0] q [N][$];
   logic [N-1:0] drop = '0;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_g, free_edge, pend_edge;
   logic [N-1:0] exp_pop, exp_push, pend_mask, pop_seen;
   logic [W-1:0] exp_data, pend_data;
   int log_dev[$];
   int log_cyc[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [N-1:0] presented();
      logic [N-1:0] p;
      for (int d = 0; d < N; d++) p[d] = (q[d].size() > 0) && !drop[d];
      return p;
   endfunction

   // Delivery rule from the destination ID in the top byte.
   function automatic logic [N-1:0] deliver(input logic [W-1:0] w, input int src);
      logic [N-1:0] m;
      int id;
      id = int'(w[W-1 -: 8]);
      m  = '0;
      if (id == 255) begin
         m = '1;
         m[src] = 1'b0;
      end else if (id < N) begin
         m[id] = 1'b1;
      end
      return m;
   endfunction

   task automatic drive();
      pndng[0] = presented();
      for (int d = 0; d < N; d++) D_pop[0][d] = (q[d].size() > 0) ? q[d][0] : '0;
   endtask

   // Predicts outputs seen after the coming edge from the inputs presented now.
   task automatic model_edge();
      logic [N-1:0] pn;
      int g;
      pn = presented();
      exp_pop  = '0;
      exp_push = '0;
      if (reset) begin
         exp_data = '0;
         return;
      end
      if (pend_edge == cyc) begin
         exp_push  = pend_mask;
         exp_data  = pend_data;
         pend_edge = -1;
      end
      if (cyc >= free_edge && pn != '0) begin
         g = -1;
         for (int i = 1; i <= N; i++) begin
            int c;
            c = (last_g + i) % N;
            if (g < 0 && pn[c]) g = c;
         end
         exp_pop    = '0;
         exp_pop[g] = 1'b1;
         pend_data  = q[g][0];
         pend_mask  = deliver(q[g][0], g);
         pend_edge  = cyc + 1;
         free_edge  = cyc + 3;
         last_g     = g;
      end
   endtask

   task automatic tick();
      drive();
      @(negedge clk);
      pop_seen = pop[0];
      model_edge();
      @(posedge clk);
      cyc++;
      #1;
      for (int d = 0; d < N; d++)
         if (pop_seen[d] && q[d].size() > 0) q[d].delete(0);
      drive();
      chk("pop", 64'(pop[0]), 64'(exp_pop));
      chk("push", 64'(push[0]), 64'(exp_push));
      chk("d_push", 64'(D_push[0]), {4{exp_data}});
      for (int d = 0; d < N; d++)
         if (pop[0][d]) begin
            log_dev.push_back(d);
            log_cyc.push_back(cyc);
         end
   endtask

   task automatic reset_pulse();
      reset     = 1'b1;
      drop      = '0;
      last_g    = N - 1;
      free_edge = 0;
      pend_edge = -1;
      exp_data  = '0;
      #1;
      chk("rst_pop", 64'(pop[0]), 64'd0);
      chk("rst_push", 64'(push[0]), 64'd0);
      chk("rst_d_push", 64'(D_push[0]), 64'd0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 ||
              cyc < free_edge || pend_edge >= 0) && n < max) begin
         tick();
         n++;
      end
      chk("drain_bound", 64'(n < max), 64'd1);
   endtask

   initial begin
      drive();
      reset_pulse();
      repeat (3) tick();

      // Every device pending with two packets: strict rotation, 3 cycles apart.
      log_dev.delete();
      log_cyc.delete();
      for (int d = 0; d < N; d++)
         for (int j = 0; j < 2; j++)
            q[d].push_back({8'((d + j) % N), 8'($urandom)});
      drain(100);
      chk("burst_count", 64'(log_dev.size()), 64'd8);
      for (int i = 0; i < log_dev.size() && i < 8; i++) begin
         chk("burst_order", 64'(log_dev[i]), 64'(i % N));
         if (i > 0) chk("burst_gap", 64'(log_cyc[i] - log_cyc[i-1]), 64'd3);
      end

      q[0].push_back(16'h02AB);
      drain(50);
      chk("d_push_hold", 64'(D_push[0][2]), 64'h02AB);

      q[1].push_back(16'hFF55);
      drain(50);

      q[3].push_back(16'h0711);
      drain(50);

      // pndng falls while the POP is in flight; the transfer still completes.
      q[2].push_back(16'h0122);
      tick();
      drop = 4'b0100;
      tick();
      tick();
      drop = '0;
      drain(50);

      // Reset in the POP cycle of device 1, then compete 0/1/2 afterwards.
      q[1].push_back(16'h0033);
      tick();
      chk("pre_rst_pop", 64'(pop[0]), 64'b0010);
      reset_pulse();
      q[0].push_back(16'h0144);
      q[2].push_back(16'h0255);
      log_dev.delete();
      log_cyc.delete();
      drain(100);
      chk("rr_after_rst", 64'(log_dev.size() > 0 ? log_dev[0] : -1), 64'd0);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            int r;
            logic [7:0] id;
            r = $urandom_range(0, 5);
            if (r < 4)       id = 8'(r);
            else if (r == 4) id = 8'hFF;
            else             id = 8'($urandom_range(4, 254));
            q[$urandom_range(0, N-1)].push_back({id, 8'($urandom)});
         end
         tick();
      end
      drain(3000);
      for (int d = 0; d < N; d++) chk("fifo_empty", 64'(q[d].size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bs_gnrtr_n_rbtr.md
BS_GNRTR_N_RBTR -- requirements
Module: bs_gnrtr_n_rbtr

Interface
REQ-001 Parameter `bits`, default 1: number of independent parallel buses.
REQ-002 Parameter `drvrs`, default 4: number of devices per bus.
REQ-003 Parameter `pckg_sz`, default 16: packet width in bits; SHALL be at least 9.
REQ-004 Parameter `broadcast`, default 8'hFF: destination ID that addresses all devices.
REQ-005 `clk`  in  1: single clock; all logic on its rising edge.
REQ-006 `reset`  in  1: asynchronous, active-high reset.
REQ-007 `pndng`  in  [bits-1:0][drvrs-1:0]: device FIFO non-empty.
REQ-008 `D_pop`  in  [bits-1:0][drvrs-1:0][pckg_sz-1:0]: device FIFO head word, first-word-fall-through.
REQ-009 `pop`  out  [bits-1:0][drvrs-1:0]: one-cycle read strobe to device FIFO.
REQ-010 `push`  out  [bits-1:0][drvrs-1:0]: one-cycle write strobe to device receive side.
REQ-011 `D_push`  out  [bits-1:0][drvrs-1:0][pckg_sz-1:0]: bus word presented to each device.
REQ-012 Port names SHALL match the `bus_if` interface signals one-to-one.

Function
REQ-013 Packet format: bits [pckg_sz-1:pckg_sz-8] = destination ID; the remaining low bits = payload.
REQ-014 Each bus index b SHALL operate fully independently, with its own FSM and arbiter.
REQ-015 FSM states: IDLE, POP, PUSH.
REQ-016 IDLE with any pndng[b] bit set: grant one requester round-robin and go to POP; otherwise stay in IDLE.
REQ-017 Round-robin search SHALL start at (last granted + 1) mod drvrs; after reset the pointer is drvrs-1, so device 0 wins first.
REQ-018 POP: pop[b][g]=1 for exactly one cycle; D_pop[b][g] SHALL be registered on that edge; next state is PUSH.
REQ-019 PUSH: all D_push[b][*] = captured word; push[b][ID]=1 for exactly one cycle; next state is IDLE.
REQ-020 ID == broadcast: push[b][k]=1 for every k ≠ source; the source SHALL NOT receive its own broadcast.
REQ-021 ID == source (not broadcast): the packet SHALL be delivered to the source.
REQ-022 ID ≥ drvrs and ≠ broadcast: the packet SHALL be popped and dropped, with no push that cycle.
REQ-023 Latency: pndng sampled in IDLE at edge k; pop high during cycle k+1; push high during cycle k+2; one packet per bus every 3 cycles.
REQ-024 pop and push SHALL be registered outputs, never asserted simultaneously on one bus, and never more than one pop bit per bus.
REQ-025 D_push SHALL hold its last value outside PUSH.
REQ-026 A device's pndng dropping during POP SHALL NOT abort the transfer; the word captured at the POP edge is used.

Reset
REQ-027 While reset=1, asynchronously: all pop=0, push=0, D_push=0; every FSM in IDLE; RR pointer = drvrs-1.
REQ-028 Reset mid-POP or mid-PUSH SHALL discard the in-flight packet; the first grant after release starts from IDLE.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, ID width constant (8) and broadcast default.
REQ-030 One sub-module `bus_lane` (single-bus FSM + RR arbiter, parameterized by `drvrs`, `pckg_sz`, `broadcast`) SHALL be instantiated `bits` times via generate.
REQ-031 Target size: 120–400 lines of RTL.

Verification (bits=1, drvrs=4, pckg_sz=16, broadcast=8'hFF)
REQ-032 Assert reset for 20 ns → pop=0, push=0, D_push=0, no activity until pndng rises.
REQ-033 Device 0 pndng with D_pop=16'h02AB → pop[0] for one cycle, then push[2]=1 only, with D_push=16'h02AB.
REQ-034 Device 1 sends 16'hFF55 → push[0], push[2], push[3]=1 in the same cycle; push[1]=0.
REQ-035 pndng=4'b1111 held, each device with 2 packets → pop order 0,1,2,3,0,1,2,3, one pop every 3 cycles.
REQ-036 Device 3 sends 16'h0711 → pop[3] pulses; no push at all.
REQ-037 Reset asserted during the POP cycle → outputs 0 immediately, no push follows, next grant is device 0.
